// File: rtl/memory_port_arbiter.sv
// Arbitrates one memory controller port between fetch and load/store, one transaction at a time.
// Optional fetch starvation guard: define MEMORY_PORT_ARBITER_STARVE_GUARD_EN.
module memory_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [1:0]        ls_width_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_done_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic [ADDR_W-1:0] mem_read_address_o,
    input  logic [DATA_W-1:0] mem_read_data_i,
    output logic [1:0]        mem_write_width_o,
    output logic [ADDR_W-1:0] mem_write_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              mem_write_enable_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [1:0]  WIDTH_WORD = 2'b10;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("memory_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be within 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_ls_q, owner_ls_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        width_q, width_d;
    logic              wen_q, wen_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_gnt_c, ls_gnt_c;
    logic              force_if;

`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
    logic [CNT_W-1:0]  starve_q, starve_d;
    assign force_if = (starve_q == CNT_W'(STARVE_LIMIT));
`else
    assign force_if = 1'b0;
`endif

    // Next-state, grant and capture logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_ls_d = owner_ls_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        width_d    = width_q;
        wen_d      = 1'b0;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_gnt_c   = 1'b0;
        ls_gnt_c   = 1'b0;
`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
        starve_d   = starve_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rst_i) begin
                    if (ls_req_i && !(if_req_i && force_if)) begin
                        ls_gnt_c   = 1'b1;
                        owner_ls_d = 1'b1;
                        addr_d     = ls_addr_i;
                        wdata_d    = ls_wdata_i;
                        width_d    = ls_width_i;
                        wen_d      = ls_we_i;
                        cnt_d      = CNT_W'(MEM_LATENCY - 1);
                        state_d    = S_ACCESS;
`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
                        if (if_req_i) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
`endif
                    end else if (if_req_i) begin
                        if_gnt_c   = 1'b1;
                        owner_ls_d = 1'b0;
                        addr_d     = if_addr_i;
                        wdata_d    = '0;
                        width_d    = WIDTH_WORD;
                        cnt_d      = CNT_W'(MEM_LATENCY - 1);
                        state_d    = S_ACCESS;
`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
                        starve_d   = '0;
`endif
                    end
                end
            end
            S_ACCESS: begin
                // Read data is sampled on the last latency cycle and handed back in RESP
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (owner_ls_q) begin
                        ls_rdata_d = mem_read_data_i;
                        ls_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_read_data_i;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            width_q    <= '0;
            wen_q      <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_ls_q <= owner_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            width_q    <= width_d;
            wen_q      <= wen_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

    assign if_gnt_o            = if_gnt_c;
    assign ls_gnt_o            = ls_gnt_c;
    assign if_done_o           = if_done_q;
    assign ls_done_o           = ls_done_q;
    assign if_rdata_o          = if_rdata_q;
    assign ls_rdata_o          = ls_rdata_q;
    assign mem_read_address_o  = addr_q;
    assign mem_write_address_o = addr_q;
    assign mem_write_data_o    = wdata_q;
    assign mem_write_width_o   = width_q;
    assign mem_write_enable_o  = wen_q;
    assign busy_o              = (state_q != S_IDLE);

endmodule
